// File: rtl/gate_lab_pkg.sv
// Shared definitions for the gate lab checker: state encodings, the FSM
// state type and the truth tables of the common two-input gates.
package gate_lab_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETTLE = ST_SETTLE,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_t;

    // Truth tables are indexed by {a,b}: bit 3 is a=1,b=1.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Expected gate output for one input vector.
    function automatic logic expected_bit(input logic [3:0] truth, input logic [1:0] vec);
        return truth[vec];
    endfunction

endpackage

// File: rtl/gate_vec_checker_settle_timer.sv
// Settle timer: loads SETTLE_CYCLES-1 and counts down to zero, so a vector
// applied on the load edge has been stable for SETTLE_CYCLES cycles by the
// time the zero flag lets the FSM move to sampling.
module settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    localparam int W = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [W-1:0] RELOAD = W'(SETTLE_CYCLES - 1);

    logic [W-1:0] count;

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_vec_checker.sv
// Stimulus-and-check stage for a two-input gate under test. Sweeps {a,b}
// through 00,01,10,11 PASSES times, samples x after each settle interval,
// and reports the mismatch count, the first failing vector and pass/fail.
module gate_vec_checker
    import gate_lab_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int PASSES        = 300,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       truth,
    input  logic             x,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    state_t           state;
    logic [1:0]       vec;
    logic [PW-1:0]    pass_cnt;
    logic             start_ok;
    logic             mismatch;
    logic             last_vec;
    logic [CNT_W-1:0] err_next;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;

    assign a = vec[1];
    assign b = vec[0];

    // Next-value helpers shared by the FSM and the settle timer control.
    always_comb begin
        start_ok   = start && ((state == IDLE) || (state == DONE));
        mismatch   = (x != expected_bit(truth, vec));
        last_vec   = (vec == 2'b11) && (pass_cnt == LAST_PASS);
        err_next   = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_next = err_cnt + 1'b1;
        end
        timer_load = start_ok || ((state == SAMPLE) && !last_vec);
        timer_dec  = (state == SETTLE);
    end

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .load(timer_load),
        .dec (timer_dec),
        .zero(timer_zero)
    );

    // Run sequencing, vector stepping and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec             <= 2'b00;
            pass_cnt        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_cnt         <= '0;
            first_err_vec   <= 2'b00;
            first_err_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state           <= SETTLE;
                        vec             <= 2'b00;
                        pass_cnt        <= '0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_cnt         <= '0;
                        first_err_vec   <= 2'b00;
                        first_err_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_cnt <= err_next;
                    if (mismatch && !first_err_valid) begin
                        first_err_vec   <= vec;
                        first_err_valid <= 1'b1;
                    end
                    if (last_vec) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end else begin
                        state <= SETTLE;
                        vec   <= vec + 2'b01;
                        if (vec == 2'b11) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vec_checker.sv
// Self-checking bench for gate_vec_checker. The gate under test is modelled
// as a 4-entry lookup table so correct, stuck and wrong gates can be drawn
// at random; a second instance with a 2-bit counter exercises saturation.
module tb_gate_vec_checker;
    import gate_lab_pkg::*;

    localparam int S          = 2;
    localparam int P          = 3;
    localparam int RUN_CYCLES = 4 * P * (S + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] truth;
    logic [3:0] gfun;
    logic       x;
    logic       a, b, busy, done, pass;
    logic [15:0] err_cnt;
    logic [1:0] first_err_vec;
    logic       first_err_valid;

    logic       x_s;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [1:0] err_cnt_s;
    logic [1:0] first_err_vec_s;
    logic       first_err_valid_s;

    int checks   = 0;
    int failures = 0;

    assign x   = gfun[{a, b}];
    assign x_s = ~(a_s & b_s);

    gate_vec_checker #(.SETTLE_CYCLES(S), .PASSES(P), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .truth(truth), .x(x),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_err_vec(first_err_vec),
        .first_err_valid(first_err_valid)
    );

    gate_vec_checker #(.SETTLE_CYCLES(S), .PASSES(P), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .truth(TT_AND), .x(x_s),
        .a(a_s), .b(b_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_cnt(err_cnt_s), .first_err_vec(first_err_vec_s),
        .first_err_valid(first_err_valid_s)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Total mismatches over a run: each differing table entry is hit once per sweep.
    function automatic int modelErrs(input logic [3:0] t, input logic [3:0] g);
        int n = 0;
        for (int v = 0; v < 4; v++) begin
            if (t[v] != g[v]) n++;
        end
        return n * P;
    endfunction

    // First failing vector in sweep order (00,01,10,11), or -1 when none.
    function automatic int modelFirst(input logic [3:0] t, input logic [3:0] g);
        for (int v = 0; v < 4; v++) begin
            if (t[v] != g[v]) return v;
        end
        return -1;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ab"}, {a, b}, 2'b00);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_pass"}, pass, 1'b0);
        checkOutput({tag, "_err"}, err_cnt, 16'd0);
        checkOutput({tag, "_fvalid"}, first_err_valid, 1'b0);
        checkOutput({tag, "_fvec"}, first_err_vec, 2'b00);
    endtask

    // One run: start pulse, per-cycle vector/busy checks, then end-of-run
    // results. early_start adds an ignored start at cycle 5; rst_at > 0
    // aborts the run with a reset sampled at that cycle.
    task automatic applyStimulus(input logic [3:0] t, input logic [3:0] g,
                                 input bit early_start, input int rst_at);
        int  exp_errs;
        int  exp_first;
        bit  aborted;
        exp_errs  = modelErrs(t, g);
        exp_first = modelFirst(t, g);
        aborted   = 1'b0;
        truth = t;
        gfun  = g;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < RUN_CYCLES; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if ((rst_at > 0) && (k == rst_at)) begin
                checkResetState("midrun_rst");
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            checkOutput("vec", {a, b}, (k / (S + 1)) % 4);
            checkOutput("busy", busy, 1'b1);
            checkOutput("done_early", done, 1'b0);
            if (k == 0) begin
                checkOutput("start_clr_err", err_cnt, 16'd0);
                checkOutput("start_clr_fvalid", first_err_valid, 1'b0);
                checkOutput("start_clr_pass", pass, 1'b0);
            end
            if (early_start && (k == 4)) start = 1'b1;
            if (early_start && (k == 5)) start = 1'b0;
            if ((rst_at > 0) && (k == rst_at - 1)) rst = 1'b1;
        end
        if (!aborted) begin
            @(posedge clk); #1;
            checkOutput("done", done, 1'b1);
            checkOutput("busy_end", busy, 1'b0);
            checkOutput("ab_end", {a, b}, 2'b11);
            checkOutput("err_cnt", err_cnt, exp_errs);
            checkOutput("pass", pass, (exp_errs == 0));
            checkOutput("fvalid", first_err_valid, (exp_first >= 0));
            checkOutput("fvec", first_err_vec, (exp_first >= 0) ? exp_first : 0);
            checkOutput("sat_err", err_cnt_s, 2'd3);
            checkOutput("sat_fvec", first_err_vec_s, 2'b00);
            checkOutput("sat_pass", pass_s, 1'b0);
            checkOutput("sat_done", done_s, 1'b1);
            repeat (3) @(posedge clk);
            #1;
            checkOutput("done_hold", done, 1'b1);
            checkOutput("err_hold", err_cnt, exp_errs);
            checkOutput("ab_hold", {a, b}, 2'b11);
        end
    endtask

    // Directed scenarios first, then random truth tables and gates.
    initial begin
        logic [3:0] t;
        logic [3:0] g;
        rst   = 1'b1;
        start = 1'b0;
        truth = TT_AND;
        gfun  = TT_AND;
        repeat (2) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("reset_sat_err", err_cnt_s, 2'd0);
        rst = 1'b0;

        $display("[TB] correct AND gate");
        applyStimulus(TT_AND, TT_AND, 1'b0, 0);
        $display("[TB] stuck-at-0 gate");
        applyStimulus(TT_AND, 4'b0000, 1'b0, 0);
        $display("[TB] OR gate against AND table");
        applyStimulus(TT_AND, TT_OR, 1'b0, 0);
        $display("[TB] reset in the middle of a run");
        applyStimulus(TT_AND, TT_OR, 1'b0, 10);
        $display("[TB] start while busy is ignored");
        applyStimulus(TT_AND, TT_AND, 1'b1, 0);
        $display("[TB] failing run then restart from done");
        applyStimulus(TT_AND, TT_XOR, 1'b0, 0);
        applyStimulus(TT_AND, TT_AND, 1'b0, 0);

        $display("[TB] random gates and tables");
        for (int i = 0; i < 8; i++) begin
            t = 4'($urandom);
            g = ($urandom_range(0, 2) == 0) ? t : 4'($urandom);
            applyStimulus(t, g, 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
